// File: rtl/fetch_pkg.sv
// Shared types, sizing constants and helpers for the fetch sequencer.
// Line geometry, queue depth and outstanding-request limits all live here.
package fetch_pkg;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    localparam int LINE_BYTES     = 64;
    localparam int INSTS_PER_LINE = 16;
    localparam int PAIRS_PER_LINE = 8;
    localparam int IQ_LINES       = 2;
    localparam int MAX_OUTST      = 2;

    localparam int CREDIT_W   = $clog2(IQ_LINES + 1);
    localparam int OUTST_W    = $clog2(MAX_OUTST + 1);
    localparam int PAIR_W     = $clog2(PAIRS_PER_LINE);
    localparam int LINE_OFS_W = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic logic [63:0] line_align(input logic [63:0] pc);
        return {pc[63:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: redirect, ICache request/response and queue write/dequeue.
// master = fetch sequencer, slave = surrounding environment (backend, ICache, queue).
interface fetch_ctrl_if;

    logic         redirect_vld;
    logic [63:0]  redirect_pc;

    logic         ic_req_vld;
    logic         ic_req_rdy;
    logic [63:0]  ic_req_pc;
    logic         ic_req_tag;

    logic         ic_rsp_vld;
    logic         ic_rsp_tag;
    logic [63:0]  ic_rsp_pc;
    logic [511:0] ic_rsp_data;

    logic         iq_wr_vld;
    logic [63:0]  iq_wr_pc;
    logic [511:0] iq_wr_data;
    logic         iq_rd;

    modport master (
        input  redirect_vld, redirect_pc,
        input  ic_req_rdy,
        input  ic_rsp_vld, ic_rsp_tag, ic_rsp_pc, ic_rsp_data,
        input  iq_rd,
        output ic_req_vld, ic_req_pc, ic_req_tag,
        output iq_wr_vld, iq_wr_pc, iq_wr_data
    );

    modport slave (
        output redirect_vld, redirect_pc,
        output ic_req_rdy,
        output ic_rsp_vld, ic_rsp_tag, ic_rsp_pc, ic_rsp_data,
        output iq_rd,
        input  ic_req_vld, ic_req_pc, ic_req_tag,
        input  iq_wr_vld, iq_wr_pc, iq_wr_data
    );

endinterface

// File: rtl/fetch_credit_ctr.sv
// Line-credit, outstanding-request and dequeued-pair bookkeeping for the fetch sequencer.
// A credit is one free queue line; it comes back after a full line of pairs is dequeued.
module fetch_credit_ctr
    import fetch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    input  logic rsp,
    input  logic stale,
    input  logic rd,
    input  logic redirect,
    output logic can_issue,
    output logic can_issue_next
);

    logic [CREDIT_W-1:0] credits_reg, credits_next;
    logic [OUTST_W-1:0]  outst_reg,   outst_next;
    logic [PAIR_W-1:0]   pair_reg,    pair_next;
    logic                pair_wrap;

    always_comb begin
        outst_next   = outst_reg + OUTST_W'(issue) - OUTST_W'(rsp);
        pair_wrap    = rd && (pair_reg == PAIR_W'(PAIRS_PER_LINE - 1));
        pair_next    = pair_reg + PAIR_W'(rd);
        credits_next = credits_reg - CREDIT_W'(issue) + CREDIT_W'(stale)
                       + CREDIT_W'(pair_wrap);
        // A flush empties the queue: every line not still in flight is free again.
        if (redirect) begin
            pair_next    = '0;
            credits_next = CREDIT_W'(IQ_LINES) - CREDIT_W'(outst_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_reg <= CREDIT_W'(IQ_LINES);
            outst_reg   <= '0;
            pair_reg    <= '0;
        end else begin
            credits_reg <= credits_next;
            outst_reg   <= outst_next;
            pair_reg    <= pair_next;
        end
    end

    assign can_issue      = (credits_reg  != '0) && (outst_reg  < OUTST_W'(MAX_OUTST));
    assign can_issue_next = (credits_next != '0) && (outst_next < OUTST_W'(MAX_OUTST));

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end fetch sequencer: issues line requests, forwards current-epoch responses
// to the instruction queue, and drops lines fetched before the latest redirect.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  bus
);

    state_t      state_reg, state_next;
    logic [63:0] fetch_pc_reg;
    logic        epoch_reg;

    logic        req_vld;
    logic        issue;
    logic        tag_match;
    logic        rsp_live;
    logic        rsp_stale;
    logic        can_issue;
    logic        can_issue_next;

    assign tag_match = (bus.ic_rsp_tag == epoch_reg);
    assign rsp_live  = bus.ic_rsp_vld &&  tag_match && !bus.redirect_vld;
    assign rsp_stale = bus.ic_rsp_vld && !tag_match && !bus.redirect_vld;

    // Request valid depends only on registered state, so it cannot loop through issue.
    assign req_vld = (state_reg == ST_FETCH) && can_issue && !bus.redirect_vld;
    assign issue   = req_vld && bus.ic_req_rdy;

    fetch_credit_ctr u_cred (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue          (issue),
        .rsp            (bus.ic_rsp_vld),
        .stale          (rsp_stale),
        .rd             (bus.iq_rd),
        .redirect       (bus.redirect_vld),
        .can_issue      (can_issue),
        .can_issue_next (can_issue_next)
    );

    // Transitions look at next-cycle resources so a returned credit issues one cycle later.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_BOOT:  state_next = ST_FETCH;
            ST_FETCH: state_next = can_issue_next ? ST_FETCH : ST_WAIT;
            ST_WAIT:  if (can_issue_next) state_next = ST_FETCH;
            default:  state_next = ST_BOOT;
        endcase
        if (bus.redirect_vld) state_next = ST_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            epoch_reg    <= 1'b0;
        end else begin
            if (bus.redirect_vld) begin
                fetch_pc_reg <= line_align(bus.redirect_pc);
                epoch_reg    <= ~epoch_reg;
            end else if (state_reg == ST_BOOT) begin
                fetch_pc_reg <= RESET_PC;
            end else if (issue) begin
                fetch_pc_reg <= fetch_pc_reg + 64'(LINE_BYTES);
            end
        end
    end

    assign bus.ic_req_vld = req_vld;
    assign bus.ic_req_pc  = fetch_pc_reg;
    assign bus.ic_req_tag = epoch_reg;
    assign bus.iq_wr_vld  = rsp_live;
    assign bus.iq_wr_pc   = bus.ic_rsp_pc;
    assign bus.iq_wr_data = bus.ic_rsp_data;

endmodule
